clk_period_meter: RTL

- Measures a slow periodic digital signal against the system clock, e.g. the output of the team's clock divider.
- Reports, per full cycle of that signal, its period and its high time in clk cycles.
- Sits in the receiving clock domain: the input is synchronized, edge-detected, then counted.
- Used for self-check of divider outputs and for monitoring externally supplied slow clocks.

---
 rtl/clk_meas_pkg.sv | 14 +
 rtl/sync_edge_det.sv | 39 +++
 rtl/clk_period_meter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/clk_meas_pkg.sv
// Shared types and default sizing for the slow-clock period meter.
package clk_meas_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } meas_state_t;

    localparam int unsigned CNT_WIDTH_DEF   = 16;
    localparam int unsigned SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer with an edge-history flop; emits the synced level
// and single-cycle rise/fall strobes in the receiving clock domain.
module sync_edge_det
    import clk_meas_pkg::*;
#(
    parameter int unsigned STAGES = SYNC_STAGES_DEF
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_sig,
    output logic o_synced,
    output logic o_rise,
    output logic o_fall
);

    if (STAGES < 2) begin : g_bad_stages
        $error("sync_edge_det: STAGES must be 2 or more");
    end

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              w_synced;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_sig};
            r_prev <= w_synced;
        end
    end

    assign w_synced = r_sync[STAGES-1];
    assign o_synced = w_synced;
    assign o_rise   = w_synced & ~r_prev;
    assign o_fall   = ~w_synced & r_prev;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow signal in clk cycles, one report per
// full cycle of the signal, with an overflow pulse when no rise arrives in time.
module clk_period_meter
    import clk_meas_pkg::*;
#(
    parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 sig_in,
    output logic [CNT_WIDTH-1:0] period,
    output logic [CNT_WIDTH-1:0] high_time,
    output logic                 meas_valid,
    output logic                 overflow
);

    // Counter carries one extra bit so it can reach the 2^CNT_WIDTH threshold.
    localparam logic [CNT_WIDTH:0]   OVF_LIMIT = {1'b1, {CNT_WIDTH{1'b0}}};
    localparam logic [CNT_WIDTH:0]   CNT_ONE   = {{CNT_WIDTH{1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] MAX_VAL   = {CNT_WIDTH{1'b1}};

    logic w_synced;
    logic w_rise;
    logic w_fall;

    sync_edge_det #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_sig    (sig_in),
        .o_synced (w_synced),
        .o_rise   (w_rise),
        .o_fall   (w_fall)
    );

    meas_state_t          r_state;
    meas_state_t          w_state_nxt;
    logic [CNT_WIDTH:0]   r_cnt;
    logic [CNT_WIDTH:0]   w_cnt_nxt;
    logic [CNT_WIDTH-1:0] r_hold;
    logic [CNT_WIDTH-1:0] w_hold_nxt;
    logic [CNT_WIDTH-1:0] r_period;
    logic [CNT_WIDTH-1:0] w_period_nxt;
    logic [CNT_WIDTH-1:0] r_high;
    logic [CNT_WIDTH-1:0] w_high_nxt;
    logic                 r_valid;
    logic                 w_valid_nxt;
    logic                 r_ovf;
    logic                 w_ovf_nxt;
    logic                 w_at_limit;
    logic [CNT_WIDTH-1:0] w_elapsed_sat;

    assign w_at_limit    = (r_cnt == OVF_LIMIT);
    // A rise coinciding with the threshold still reports, clamped to the max.
    assign w_elapsed_sat = w_at_limit ? MAX_VAL : r_cnt[CNT_WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_hold   <= '0;
            r_period <= '0;
            r_high   <= '0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_hold   <= w_hold_nxt;
            r_period <= w_period_nxt;
            r_high   <= w_high_nxt;
            r_valid  <= w_valid_nxt;
            r_ovf    <= w_ovf_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_hold_nxt   = r_hold;
        w_period_nxt = r_period;
        w_high_nxt   = r_high;
        w_valid_nxt  = 1'b0;
        w_ovf_nxt    = 1'b0;

        if (!enable) begin
            w_state_nxt = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_state_nxt = ARM;
                end
                ARM: begin
                    if (w_rise) begin
                        w_state_nxt = HIGH;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
                HIGH: begin
                    if (w_rise) begin
                        // Missed fall: restart from this rise, nothing reported.
                        w_cnt_nxt = CNT_ONE;
                    end else if (w_at_limit) begin
                        w_ovf_nxt   = 1'b1;
                        w_state_nxt = ARM;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                        if (w_fall) begin
                            w_hold_nxt  = r_cnt[CNT_WIDTH-1:0];
                            w_state_nxt = LOW;
                        end
                    end
                end
                LOW: begin
                    if (w_rise) begin
                        w_period_nxt = w_elapsed_sat;
                        w_high_nxt   = r_hold;
                        w_valid_nxt  = 1'b1;
                        w_cnt_nxt    = CNT_ONE;
                        w_state_nxt  = HIGH;
                    end else if (w_at_limit) begin
                        w_ovf_nxt   = 1'b1;
                        w_state_nxt = ARM;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign period     = r_period;
    assign high_time  = r_high;
    assign meas_valid = r_valid;
    assign overflow   = r_ovf;

    // While LOW the synced level can only return high through a detected rise.
    a_low_level: assert property (@(posedge clk) disable iff (reset)
        (r_state == LOW && w_synced) |-> w_rise);

    a_pulse_excl: assert property (@(posedge clk) disable iff (reset)
        !(r_valid && r_ovf));

endmodule
